// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    BR_PEND  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// hit pulses on the increment that brings the count to MAX.
module sat_counter #(
  parameter int unsigned MAX   = 16,
  parameter int unsigned WIDTH = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_max;

  assign at_max = (count_q == WIDTH'(MAX));
  assign hit    = inc && !clr && (count_q == WIDTH'(MAX - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory wait, branch flush and load-use stall.
// Optional performance counters are enabled with PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_br_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ack,
  output logic                  pc_ld_n,
  output logic                  if_id_ld_n,
  output logic                  id_ex_ld_n,
  output logic                  ex_mem_ld_n,
  output logic                  mem_wb_ld_n,
  output logic                  if_id_clr,
  output logic                  id_ex_clr,
  output logic                  ex_mem_clr,
  output logic                  mem_wb_clr,
  output logic [1:0]            state,
  output logic                  mem_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  ctrl_state_t state_q, state_d;
  logic        br_pend_q, br_pend_d;
  logic        mem_timeout_q;
  logic        mem_wait, wait_exit, br_flush, lu_hit, load_use;
  logic        wait_hit;

  // Once in MEM_WAIT only the ack matters; the request is assumed held.
  assign mem_wait  = (state_q == MEM_WAIT) ? !dmem_ack : (dmem_req && !dmem_ack);
  assign wait_exit = (state_q == MEM_WAIT) && dmem_ack;
  assign br_flush  = !mem_wait && (ex_br_taken || (wait_exit && br_pend_q));

  assign lu_hit = ex_is_load && (ex_rd != '0) &&
                  ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
  assign load_use = !mem_wait && !br_flush && lu_hit && (state_q != LU_STALL);

  always_comb begin
    state_d   = RUN;
    br_pend_d = 1'b0;
    if (mem_wait) begin
      state_d   = MEM_WAIT;
      br_pend_d = br_pend_q || ex_br_taken;
    end else if (wait_exit && br_pend_q) begin
      state_d = BR_PEND;
    end else if (load_use) begin
      state_d = LU_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      br_pend_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      br_pend_q     <= br_pend_d;
      mem_timeout_q <= mem_timeout_q || wait_hit;
    end
  end

  // Counts every frozen cycle, including the one that enters MEM_WAIT.
  sat_counter #(
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_exit),
    .inc   (mem_wait),
    .hit   (wait_hit)
  );

  always_comb begin
    pc_ld_n     = 1'b0;
    if_id_ld_n  = 1'b0;
    id_ex_ld_n  = 1'b0;
    ex_mem_ld_n = 1'b0;
    mem_wb_ld_n = 1'b0;
    if_id_clr   = 1'b0;
    id_ex_clr   = 1'b0;
    ex_mem_clr  = 1'b0;
    mem_wb_clr  = 1'b0;
    if (!rst_n) begin
      pc_ld_n     = 1'b1;
      if_id_ld_n  = 1'b1;
      id_ex_ld_n  = 1'b1;
      ex_mem_ld_n = 1'b1;
      mem_wb_ld_n = 1'b1;
      if_id_clr   = 1'b1;
      id_ex_clr   = 1'b1;
      ex_mem_clr  = 1'b1;
      mem_wb_clr  = 1'b1;
    end else if (mem_wait) begin
      pc_ld_n     = 1'b1;
      if_id_ld_n  = 1'b1;
      id_ex_ld_n  = 1'b1;
      ex_mem_ld_n = 1'b1;
      mem_wb_clr  = 1'b1;
    end else if (br_flush) begin
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
    end else if (load_use) begin
      pc_ld_n    = 1'b1;
      if_id_ld_n = 1'b1;
      id_ex_clr  = 1'b1;
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_ld_n) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (br_flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken, dmem_req, dmem_ack;
  logic       pc_ld_n, if_id_ld_n, id_ex_ld_n, ex_mem_ld_n, mem_wb_ld_n;
  logic       if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr;
  logic [1:0] state;
  logic       mem_timeout;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb} ld_n, then {if_id, id_ex, ex_mem, mem_wb} clr
  localparam logic [8:0] NORM   = 9'b00000_0000;
  localparam logic [8:0] FREEZE = 9'b11110_0001;
  localparam logic [8:0] FLUSH  = 9'b00000_1100;
  localparam logic [8:0] LU     = 9'b11000_0100;
  localparam logic [8:0] RST    = 9'b11111_1111;

  localparam logic [1:0] S_RUN = 2'd0, S_LU = 2'd1, S_MW = 2'd2, S_BP = 2'd3;

  logic [8:0] ctl;
  assign ctl = {pc_ld_n, if_id_ld_n, id_ex_ld_n, ex_mem_ld_n, mem_wb_ld_n,
                if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MAX_WAIT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_br_taken (ex_br_taken),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .pc_ld_n     (pc_ld_n),
    .if_id_ld_n  (if_id_ld_n),
    .id_ex_ld_n  (id_ex_ld_n),
    .ex_mem_ld_n (ex_mem_ld_n),
    .mem_wb_ld_n (mem_wb_ld_n),
    .if_id_clr   (if_id_clr),
    .id_ex_clr   (id_ex_clr),
    .ex_mem_clr  (ex_mem_clr),
    .mem_wb_clr  (mem_wb_clr),
    .state       (state),
    .mem_timeout (mem_timeout)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0;
    ex_br_taken = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  // Inputs already applied just after a rising edge; check mid-cycle, then advance.
  task automatic cyc(input string tag, input logic [8:0] c, input logic [1:0] s, input logic to);
    #2;
    check({tag, ".ctl"}, 32'(ctl), 32'(c));
    check({tag, ".state"}, 32'(state), 32'(s));
    check({tag, ".timeout"}, 32'(mem_timeout), 32'(to));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check("rst.ctl", 32'(ctl), 32'(RST));
    check("rst.state", 32'(state), 32'(S_RUN));
    check("rst.timeout", 32'(mem_timeout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cyc("idle", NORM, S_RUN, 0);

    // Load-use on rs1: one stall cycle, detection suppressed while stalled.
    ex_is_load = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    cyc("lu1.hit", LU, S_RUN, 0);
    cyc("lu1.stall", NORM, S_LU, 0);
    idle_inputs();
    cyc("lu1.back", NORM, S_RUN, 0);

    // Load-use on rs2, and the same match without the valid flag.
    ex_is_load = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1;
    cyc("lu2.hit", LU, S_RUN, 0);
    idle_inputs();
    ex_is_load = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 0;
    cyc("lu2.novalid", NORM, S_LU, 0);
    cyc("lu2.novalid2", NORM, S_RUN, 0);

    // x0 is never a hazard.
    idle_inputs();
    ex_is_load = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
    cyc("x0", NORM, S_RUN, 0);
    idle_inputs();
    cyc("x0.after", NORM, S_RUN, 0);

    // Branch flush, alone and beating a simultaneous load-use.
    ex_br_taken = 1;
    cyc("br", FLUSH, S_RUN, 0);
    ex_is_load = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1;
    cyc("br_lu", FLUSH, S_RUN, 0);
    idle_inputs();
    cyc("br.after", NORM, S_RUN, 0);

    // Three-cycle memory wait.
    dmem_req = 1;
    cyc("mw.1", FREEZE, S_RUN, 0);
    cyc("mw.2", FREEZE, S_MW, 0);
    cyc("mw.3", FREEZE, S_MW, 0);
    dmem_ack = 1;
    cyc("mw.ack", NORM, S_MW, 0);
    idle_inputs();
    cyc("mw.after", NORM, S_RUN, 0);

    // Sixteen-cycle wait with a branch in cycle 2: timeout and deferred flush.
    for (int i = 1; i <= 16; i++) begin
      dmem_req = 1; dmem_ack = 0; ex_br_taken = (i == 2);
      cyc($sformatf("to.w%0d", i), FREEZE, (i == 1) ? S_RUN : S_MW, 0);
    end
    ex_br_taken = 0; dmem_ack = 1;
    cyc("to.ack", FLUSH, S_MW, 1);
    idle_inputs();
    cyc("to.brpend", NORM, S_BP, 1);
    cyc("to.run", NORM, S_RUN, 1);

    // Reset in the second MEM_WAIT cycle with a branch pending.
    dmem_req = 1;
    cyc("rw.1", FREEZE, S_RUN, 1);
    ex_br_taken = 1;
    #2;
    check("rw.2.state", 32'(state), 32'(S_MW));
    rst_n = 1'b0;
    #1;
    check("rw.rst.ctl", 32'(ctl), 32'(RST));
    check("rw.rst.state", 32'(state), 32'(S_RUN));
    check("rw.rst.timeout", 32'(mem_timeout), 32'(0));
    #1;
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    // The discarded branch must not reappear on the next ack.
    dmem_req = 1;
    cyc("rw.w", FREEZE, S_RUN, 0);
    dmem_ack = 1;
    cyc("rw.ack", NORM, S_MW, 0);
    idle_inputs();
    cyc("rw.run", NORM, S_RUN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, meaning the number of MEM_WAIT cycles without dmem_ack before mem_timeout sets.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-004 SHALL have ports id_rs1 and id_rs2, input, 5 each, ID-stage source registers.
REQ-005 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each, source-valid flags.
REQ-006 SHALL have ports ex_rd (input, 5) and ex_is_load (input, 1), describing the instruction in EX.
REQ-007 SHALL have port ex_br_taken, input, 1, branch/jump resolved taken in EX.
REQ-008 SHALL have ports dmem_req and dmem_ack, input, 1 each, MEM-stage access handshake.
REQ-009 SHALL have output pc_ld_n, 1, PC load enable, active-low.
REQ-010 SHALL have outputs if_id_ld_n, id_ex_ld_n, ex_mem_ld_n and mem_wb_ld_n, 1 each, pipeline-register load enables, active-low.
REQ-011 SHALL have outputs if_id_clr, id_ex_clr, ex_mem_clr and mem_wb_clr, 1 each, synchronous bubble insert, active-high.
REQ-012 SHALL have outputs state (2 bits, current FSM state) and mem_timeout (1 bit, sticky).

Function
REQ-013 SHALL implement FSM states RUN=0, LU_STALL=1, MEM_WAIT=2 and BR_PEND=3.
REQ-014 SHALL drive all control outputs combinationally from state and the current inputs, giving zero-cycle latency.
REQ-015 SHALL assign priority per cycle as: memory wait, then branch flush, then load-use.
REQ-016 SHALL detect memory wait as dmem_req=1 and dmem_ack=0; response: all ld_n=1 except mem_wb_ld_n, mem_wb_clr=1; next state MEM_WAIT.
REQ-017 SHALL hold MEM_WAIT until dmem_ack=1 and, in that ack cycle, load all stages normally.
REQ-018 SHALL, on ex_br_taken=1 during MEM_WAIT, latch br_pend and enter BR_PEND on ack; that ack cycle applies the branch flush (REQ-019).
REQ-019 SHALL define branch flush as ex_br_taken=1 with no memory wait; response: pc_ld_n=0, if_id_clr=1, id_ex_clr=1; other stages load normally.
REQ-020 SHALL define load-use as ex_is_load=1, ex_rd!=0, and a match of ex_rd to id_rs1 (with id_use_rs1) or to id_rs2 (with id_use_rs2).
REQ-021 SHALL respond to load-use with pc_ld_n=1, if_id_ld_n=1 and id_ex_clr=1, and enter LU_STALL for exactly one cycle.
REQ-022 SHALL suppress load-use detection in LU_STALL, then return to RUN.
REQ-023 SHALL never stall on load-use when ex_br_taken=1 in the same cycle; the flush wins.
REQ-024 SHALL count wait cycles in MEM_WAIT, saturating at MAX_WAIT.
REQ-025 SHALL set mem_timeout when the wait count reaches MAX_WAIT; the flag stays set until reset, and waiting continues.
REQ-026 SHALL clear the wait count on every MEM_WAIT exit.
REQ-027 SHALL treat BR_PEND as a one-cycle state and then return to RUN, with normal loads.
REQ-028 SHALL otherwise be in RUN with all ld_n=0 and all clr=0.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: state=RUN, br_pend=0, wait count=0, mem_timeout=0.
REQ-030 SHALL, while rst_n=0, drive all ld_n=1 and all clr=1.
REQ-031 SHALL make reset mid-MEM_WAIT discard any pending branch.
REQ-032 SHALL resume operation on the first clock after rst_n rises.

Configuration
REQ-033 SHALL, when macro PIPE_HAZARD_CTRL_PERF_EN is defined, add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-034 SHALL increment stall_cnt on each cycle with pc_ld_n=1, and flush_cnt on each applied branch flush; both wrap and reset to 0.
REQ-035 SHALL, without the macro, omit both ports and all counter logic.

Structure
REQ-036 SHALL place the state enum (ctrl_state_t) and the REG_ADDR_W=5 constant in shared package pipe_ctrl_pkg.
REQ-037 SHALL implement the saturating wait counter as sub-module sat_counter, parameterised by MAX_WAIT.

Verification
REQ-038 SHALL cover load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_ld_n=1, if_id_ld_n=1, id_ex_clr=1, then RUN.
REQ-039 SHALL cover x0 exemption: ex_rd=0, id_rs1=0, ex_is_load=1 -> no stall, all ld_n=0.
REQ-040 SHALL cover branch: ex_br_taken=1 -> same-cycle if_id_clr=id_ex_clr=1, pc_ld_n=0.
REQ-041 SHALL cover memory wait: dmem_req=1, dmem_ack low for 3 cycles -> 3 cycles frozen with mem_wb_clr=1, all stages loaded on ack, mem_timeout=0.
REQ-042 SHALL cover timeout and pending branch: ack held low 16 cycles with ex_br_taken pulsed in cycle 2 -> mem_timeout=1 at cycle 16, flush applied on ack cycle, BR_PEND for one cycle.
REQ-043 SHALL cover reset mid-wait: rst_n=0 at cycle 2 of MEM_WAIT -> immediate state=RUN, all clr=1, br_pend and counters 0.
